mvb_rx_sched: RTL and testbench
===============================

// Module: mvb_rx_sched
// PURPOSE
//  Reception scheduler for the MVB decode path. Arms the decoder with the expected frame length and waits for
//  end of frame. Then drains the decoder's 16-bit word FIFO and delivers the words to the host over a
//  valid/ready stream, finishing with a one-cycle completion pulse and a latched 8-bit status word.
//  Flushes stale or erroneous FIFO contents so that every frame starts from an empty FIFO.
// PARAMETERS
//  TMO_W    16    width of the end-of-frame timeout counter
//  TIMEOUT  2400  clk cycles allowed in WAIT_END before timeout (100 us at 24 MHz)
//  GRACE    8     clk cycles FIFO may stay empty in DRAIN before underrun is declared
// PORTS
//  clk           in   1   24 MHz system clock; also the decoder FIFO read clock
//  rst           in   1   synchronous, active-high reset
//  rx_req        in   1   host request to receive one frame; sampled only in IDLE
//  rx_len        in   5   expected data words, 1..16; latched on accepted rx_req
//  rx_abort      in   1   abandon current frame; ignored in IDLE
//  rx_busy       out  1   high in every state except IDLE
//  frame_length  out  5   to decoder frame_length; holds latched rx_len
//  frame_over    in   1   decoder frame_over_out (multi-cycle level)
//  err_in        in   5   {crc,quality,delimiter,signal,length} decoder error flags
//  fifo_empty    in   1   decoder FIFO empty
//  fifo_rden     out  1   decoder FIFO read enable; dout valid 1 cycle later
//  fifo_dout     in   16  decoder FIFO data
//  word_data     out  16  delivered word
//  word_valid    out  1   word_data valid
//  word_ready    in   1   host accepts word when valid & ready
//  word_last     out  1   high with the rx_len-th word
//  frame_done    out  1   one-cycle pulse when status is updated
//  frame_status  out  8   {overrun,underrun,timeout,crc,quality,delimiter,signal,length}
// BEHAVIOUR
//  Reset values:
//   - all outputs 0; frame_length = 0; state = IDLE; counters = 0.
//   - The FIFO itself is not reset.
//  States: IDLE, ARM, WAIT_END, DRAIN, FLUSH, REPORT.
//  IDLE:
//   - On rx_req with rx_len in 1..16: latch rx_len into frame_length, clear the status accumulator, go to ARM.
//   - rx_len 0 or >16: no arming; frame_status = 8'h01 and frame_done pulses 1 cycle later.
//  ARM (stale-word purge):
//   - While !fifo_empty, pulse fifo_rden and discard the data.
//   - A rden is issued only when no read is in flight, i.e. at most one read every 2 cycles.
//   - When fifo_empty and no read is in flight, go to WAIT_END and clear the timeout counter.
//  WAIT_END:
//   - Count clk cycles. Rising edge of frame_over (registered edge detect) latches err_in into status[4:0].
//   - If any bit is set, go to FLUSH; otherwise go to DRAIN.
//   - Counter reaching TIMEOUT: set status[5], go to FLUSH.
//   - A frame_over edge and TIMEOUT in the same cycle: frame_over wins.
//  DRAIN:
//   - Per word: fifo_rden for 1 cycle when !fifo_empty and the output register is free.
//   - Next cycle: capture fifo_dout into word_data and assert word_valid.
//   - word_data/word_valid/word_last are held stable until word_ready.
//   - The word counter increments on each handshake; word_last = (count == len-1) while valid.
//   - After the last handshake:
//     - if !fifo_empty, set status[7] (overrun) and go to FLUSH;
//     - otherwise go to REPORT.
//   - FIFO empty for GRACE consecutive cycles with words outstanding: set status[6] (underrun), go to REPORT.
//  FLUSH: same read/discard loop as ARM; when empty with no read in flight, go to REPORT.
//  REPORT: drive frame_status from the accumulator, pulse frame_done for 1 cycle, go to IDLE.
//  rx_abort:
//   - In ARM/WAIT_END/DRAIN: drop any pending word (word_valid low next cycle) and go to FLUSH.
//   - Status is unchanged by the abort.
//  rx_req outside IDLE is ignored. frame_status holds its value until the next REPORT.
//  Mid-operation rst: next edge returns to IDLE with reset values; a later rx_req purges leftovers in ARM.
// TESTING
//  1. rx_len=4; frame_over rises with err_in=0; 4 words A0..A3 in FIFO; word_ready=1
//     -> 4 handshakes, word_last on A3, frame_done, frame_status=8'h00.
//  2. Three stale words in FIFO before rx_req
//     -> ARM issues 3 rden, none appear on word_valid, then WAIT_END.
//  3. frame_over rises with err_in=5'b10000 (crc)
//     -> no word_valid, FIFO flushed to empty, frame_status=8'h10.
//  4. No frame_over within TIMEOUT=2400 cycles
//     -> frame_done at about cycle 2401+, frame_status=8'h20.
//  5. rx_len=4 with 6 words in FIFO -> 4 words delivered, 2 flushed, frame_status=8'h80.
//     rx_len=4 with 2 words in FIFO -> 2 words delivered, frame_status=8'h40 after GRACE.
//  6. word_ready low for 10 cycles mid-DRAIN -> word_data stable, no extra rden.
//     rx_abort while a word is pending -> FLUSH, frame_status=8'h00.
//     rst mid-DRAIN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mvb_rx_sched.sv
// -----------------------------------------------------------------------------
// mvb_rx_sched
//
// Reception scheduler for the MVB decode path. A host request arms the decoder
// with the expected frame length, the block purges any stale words left in the
// decoder FIFO, waits for end of frame, and then drains the decoder FIFO word
// by word onto a valid/ready stream. Every frame ends with a one-cycle
// frame_done pulse and a latched 8-bit frame_status word. Erroneous, aborted,
// timed-out or overlong frames are flushed so that the next frame starts from
// an empty FIFO.
//
// Ports
//   clk           24 MHz system clock, also the decoder FIFO read clock
//   rst           synchronous active-high reset
//   rx_req        host request to receive one frame (sampled in IDLE only)
//   rx_len        expected data words 1..16, latched on an accepted rx_req
//   rx_abort      abandon the current frame (ignored in IDLE)
//   rx_busy       high in every state except IDLE
//   frame_length  latched rx_len, drives the decoder frame_length input
//   frame_over    decoder end-of-frame level
//   err_in        {crc,quality,delimiter,signal,length} decoder error flags
//   fifo_empty    decoder FIFO empty flag
//   fifo_rden     decoder FIFO read enable; fifo_dout is valid one cycle later
//   fifo_dout     decoder FIFO read data
//   word_data     delivered word
//   word_valid    word_data valid
//   word_ready    host accepts the word when word_valid & word_ready
//   word_last     marks the rx_len-th word of the frame
//   frame_done    one-cycle pulse when frame_status is updated
//   frame_status  {overrun,underrun,timeout,crc,quality,delimiter,signal,length}
//   dbg_state     current FSM state encoding (state_t)
//
// Output stream handshake: a word is transferred on every rising clk edge at
// which word_valid and word_ready are both high. Once word_valid is raised,
// word_data, word_valid and word_last stay constant until that transfer; the
// only exceptions are rx_abort and rst, which withdraw the pending word.
// -----------------------------------------------------------------------------
module mvb_rx_sched #(
    parameter int TMO_W   = 16,
    parameter int TIMEOUT = 2400,
    parameter int GRACE   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_req,
    input  logic [4:0]  rx_len,
    input  logic        rx_abort,
    output logic        rx_busy,
    output logic [4:0]  frame_length,
    input  logic        frame_over,
    input  logic [4:0]  err_in,
    input  logic        fifo_empty,
    output logic        fifo_rden,
    input  logic [15:0] fifo_dout,
    output logic [15:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        word_last,
    output logic        frame_done,
    output logic [7:0]  frame_status,
    output logic [2:0]  dbg_state
);

    localparam int GW = $clog2(GRACE + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_WAIT_END = 3'd2,
        S_DRAIN    = 3'd3,
        S_FLUSH    = 3'd4,
        S_REPORT   = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [4:0]       frame_length_q;
    logic [7:0]       acc_q;          // status accumulator for the frame in progress
    logic [7:0]       frame_status_q;
    logic             frame_done_q;
    logic             fo_q;           // frame_over delayed, for edge detection
    logic             inflight_q;     // a FIFO read was issued last cycle
    logic [TMO_W-1:0] tmo_q;
    logic [GW-1:0]    grace_q;
    logic [4:0]       cnt_q;          // handshakes completed in this frame
    logic [15:0]      word_data_q;
    logic             word_valid_q;

    // ------------------------------------------------------------------
    // Shared event terms
    // ------------------------------------------------------------------
    logic len_ok;
    logic fo_edge;
    logic tmo_hit;
    logic handshake;
    logic last_cnt;
    logic purge_rd;
    logic purge_done;
    logic drain_rd;
    logic starve;
    logic grace_hit;

    always_comb begin
        len_ok     = (rx_len != 5'd0) && (rx_len <= 5'd16);
        fo_edge    = frame_over & ~fo_q;
        tmo_hit    = (tmo_q == TMO_W'(TIMEOUT - 1));
        handshake  = word_valid_q & word_ready;
        last_cnt   = (cnt_q == (frame_length_q - 5'd1));
        // Purge reads are spaced so the empty flag has settled before the
        // next read decision.
        purge_rd   = !fifo_empty && !inflight_q;
        purge_done = fifo_empty && !inflight_q;
        // One word in the pipe at a time: the read is issued only when the
        // output register is free and no earlier read is still landing.
        drain_rd   = !fifo_empty && !word_valid_q && !inflight_q;
        starve     = fifo_empty && !word_valid_q && !inflight_q;
        grace_hit  = starve && (grace_q == GW'(GRACE - 1));
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rx_req && len_ok) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (rx_abort) begin
                    state_d = S_FLUSH;
                end else if (purge_done) begin
                    state_d = S_WAIT_END;
                end
            end
            S_WAIT_END: begin
                // An end-of-frame edge takes priority over a simultaneous timeout.
                if (rx_abort) begin
                    state_d = S_FLUSH;
                end else if (fo_edge) begin
                    state_d = (|err_in) ? S_FLUSH : S_DRAIN;
                end else if (tmo_hit) begin
                    state_d = S_FLUSH;
                end
            end
            S_DRAIN: begin
                if (rx_abort) begin
                    state_d = S_FLUSH;
                end else if (handshake && last_cnt) begin
                    // Words left behind the last one mean the frame was too long.
                    state_d = fifo_empty ? S_REPORT : S_FLUSH;
                end else if (grace_hit) begin
                    state_d = S_REPORT;
                end
            end
            S_FLUSH: begin
                if (purge_done) begin
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        rx_busy      = (state_q != S_IDLE);
        fifo_rden    = 1'b0;
        frame_length = frame_length_q;
        word_data    = word_data_q;
        word_valid   = word_valid_q;
        word_last    = word_valid_q && last_cnt;
        frame_done   = frame_done_q;
        frame_status = frame_status_q;
        dbg_state    = state_q;
        case (state_q)
            S_ARM:   fifo_rden = purge_rd;
            S_FLUSH: fifo_rden = purge_rd;
            S_DRAIN: fifo_rden = drain_rd && !rx_abort;
            default: fifo_rden = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: counters, status accumulator, output word register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_length_q <= 5'd0;
            acc_q          <= 8'h00;
            frame_status_q <= 8'h00;
            frame_done_q   <= 1'b0;
            fo_q           <= 1'b0;
            inflight_q     <= 1'b0;
            tmo_q          <= '0;
            grace_q        <= '0;
            cnt_q          <= 5'd0;
            word_data_q    <= 16'h0000;
            word_valid_q   <= 1'b0;
        end else begin
            fo_q         <= frame_over;
            inflight_q   <= fifo_rden;
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_req) begin
                        if (len_ok) begin
                            frame_length_q <= rx_len;
                            acc_q          <= 8'h00;
                        end else begin
                            // Invalid length: report a length error straight away.
                            frame_status_q <= 8'h01;
                            frame_done_q   <= 1'b1;
                        end
                    end
                end
                S_ARM: begin
                    tmo_q   <= '0;
                    grace_q <= '0;
                    cnt_q   <= 5'd0;
                end
                S_WAIT_END: begin
                    tmo_q <= tmo_q + TMO_W'(1);
                    if (!rx_abort) begin
                        if (fo_edge) begin
                            acc_q[4:0] <= err_in;
                        end else if (tmo_hit) begin
                            acc_q[5] <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (rx_abort) begin
                        word_valid_q <= 1'b0;
                    end else begin
                        if (inflight_q) begin
                            word_data_q  <= fifo_dout;
                            word_valid_q <= 1'b1;
                        end
                        if (handshake) begin
                            word_valid_q <= 1'b0;
                            cnt_q        <= cnt_q + 5'd1;
                            if (last_cnt && !fifo_empty) begin
                                acc_q[7] <= 1'b1;
                            end
                        end
                        // Consecutive starved cycles while words are still owed.
                        if (starve) begin
                            grace_q <= grace_q + GW'(1);
                            if (grace_hit) begin
                                acc_q[6] <= 1'b1;
                            end
                        end else begin
                            grace_q <= '0;
                        end
                    end
                end
                S_FLUSH: begin
                    word_valid_q <= 1'b0;
                end
                S_REPORT: begin
                    frame_status_q <= acc_q;
                    frame_done_q   <= 1'b1;
                end
                default: begin
                    word_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mvb_rx_sched.sv
`timescale 1ns/1ps
module tb_mvb_rx_sched;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        rx_req = 1'b0;
    logic [4:0]  rx_len = 5'd0;
    logic        rx_abort = 1'b0;
    logic        rx_busy;
    logic [4:0]  frame_length;
    logic        frame_over = 1'b0;
    logic [4:0]  err_in = 5'd0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rden;
    logic [15:0] fifo_dout = 16'h0000;
    logic [15:0] word_data;
    logic        word_valid;
    logic        word_ready = 1'b1;
    logic        word_last;
    logic        frame_done;
    logic [7:0]  frame_status;
    logic [2:0]  dbg_state;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_END = 3'd2;

    mvb_rx_sched #(.TMO_W(16), .TIMEOUT(2400), .GRACE(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_req       (rx_req),
        .rx_len       (rx_len),
        .rx_abort     (rx_abort),
        .rx_busy      (rx_busy),
        .frame_length (frame_length),
        .frame_over   (frame_over),
        .err_in       (err_in),
        .fifo_empty   (fifo_empty),
        .fifo_rden    (fifo_rden),
        .fifo_dout    (fifo_dout),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .word_last    (word_last),
        .frame_done   (frame_done),
        .frame_status (frame_status),
        .dbg_state    (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rden_cnt = 0;

    logic [16:0] exp_q[$];    // {last, data}
    logic [7:0]  stat_q[$];
    logic [15:0] fifo_m[$];   // decoder FIFO contents

    always @(posedge clk) cyc++;

    // Decoder FIFO model: data appears one cycle after the read enable.
    always @(posedge clk) begin
        if (fifo_rden) begin
            rden_cnt++;
            if (fifo_m.size() > 0) fifo_dout <= fifo_m.pop_front();
        end
        fifo_empty <= (fifo_m.size() == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard monitor, sampled mid-cycle after the drivers have settled
    // ------------------------------------------------------------------
    logic        stall_prev = 1'b0;
    logic        disturb_prev = 1'b0;
    logic [15:0] stall_data = 16'h0000;

    always @(negedge clk) begin
        logic [16:0] e;
        logic [7:0]  s;
        #2;
        if (stall_prev && !disturb_prev) begin
            check("hold_valid", {31'd0, word_valid}, 32'd1);
            check("hold_data", {16'd0, word_data}, {16'd0, stall_data});
        end
        if (word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word actual=%0h required=none", {word_last, word_data});
            end else begin
                e = exp_q.pop_front();
                check("word", {15'd0, word_last, word_data}, {15'd0, e});
            end
        end
        if (frame_done) begin
            if (stat_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=%0h required=none", frame_status);
            end else begin
                s = stat_q.pop_front();
                check("status", {24'd0, frame_status}, {24'd0, s});
            end
        end
        stall_prev   = word_valid && !word_ready;
        stall_data   = word_data;
        disturb_prev = rx_abort || rst;
    end

    // ------------------------------------------------------------------
    // Driver tasks (called at a falling edge)
    // ------------------------------------------------------------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame(input logic [4:0] len);
        rx_req = 1'b1;
        rx_len = len;
        tick();
        rx_req = 1'b0;
        rx_len = 5'd0;
    endtask

    task automatic fo_pulse(input logic [4:0] err);
        err_in = err;
        frame_over = 1'b1;
        tick(3);
        frame_over = 1'b0;
        err_in = 5'd0;
    endtask

    task automatic push_words(input logic [15:0] base, input int n, input int n_exp, input int len);
        for (int i = 0; i < n; i++) begin
            fifo_m.push_back(base + 16'(i));
            if (i < n_exp) exp_q.push_back({(i == len - 1), base + 16'(i)});
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string name);
        int n = 0;
        while (dbg_state !== st && n < budget) begin
            tick();
            n++;
        end
        check(name, {29'd0, dbg_state}, {29'd0, st});
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (frame_done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(name, {31'd0, frame_done}, 32'd1);
        tick();
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (word_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(name, {31'd0, word_valid}, 32'd1);
    endtask

    function automatic logic [47:0] out_bus();
        return {rx_busy, frame_length, fifo_rden, word_data, word_valid,
                word_last, frame_done, frame_status, dbg_state, 6'd0};
    endfunction

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        int r;
        int c0;
        tick(3);
        rst = 1'b0;
        tick();
        check("reset_outputs", out_bus()[47:16], 32'd0);
        check("reset_outputs_lo", {16'd0, out_bus()[15:0]}, 32'd0);

        // 1: basic 4-word frame
        start_frame(5'd4);
        wait_state(ST_WAIT_END, 20, "t1_wait_end");
        check("t1_frame_length", {27'd0, frame_length}, 32'd4);
        check("t1_busy", {31'd0, rx_busy}, 32'd1);
        push_words(16'h00A0, 4, 4, 4);
        stat_q.push_back(8'h00);
        tick(2);
        fo_pulse(5'd0);
        wait_done(100, "t1_done");
        tick(3);

        // 2: stale words purged in ARM
        fifo_m.push_back(16'hDEAD);
        fifo_m.push_back(16'hBEEF);
        fifo_m.push_back(16'hCAFE);
        tick(2);
        r = rden_cnt;
        start_frame(5'd2);
        wait_state(ST_WAIT_END, 30, "t2_wait_end");
        check("t2_purge_rden", rden_cnt - r, 32'd3);
        push_words(16'h00B0, 2, 2, 2);
        stat_q.push_back(8'h00);
        tick(2);
        fo_pulse(5'd0);
        wait_done(100, "t2_done");
        tick(3);

        // 3: crc error -> flush, no words
        start_frame(5'd4);
        wait_state(ST_WAIT_END, 20, "t3_wait_end");
        push_words(16'h0030, 3, 0, 4);
        stat_q.push_back(8'h10);
        tick(2);
        fo_pulse(5'b10000);
        wait_done(100, "t3_done");
        check("t3_fifo_flushed", fifo_m.size(), 32'd0);
        tick(3);

        // 4: end-of-frame timeout
        stat_q.push_back(8'h20);
        c0 = cyc;
        start_frame(5'd3);
        wait_done(3000, "t4_done");
        check("t4_latency_window", {31'd0, ((cyc - c0) >= 2400) && ((cyc - c0) <= 2412)}, 32'd1);
        tick(3);

        // 5a: overrun (6 words for a 4-word frame)
        start_frame(5'd4);
        wait_state(ST_WAIT_END, 20, "t5a_wait_end");
        push_words(16'h0050, 6, 4, 4);
        stat_q.push_back(8'h80);
        tick(2);
        fo_pulse(5'd0);
        wait_done(100, "t5a_done");
        check("t5a_fifo_flushed", fifo_m.size(), 32'd0);
        tick(3);

        // 5b: underrun (2 words for a 4-word frame)
        start_frame(5'd4);
        wait_state(ST_WAIT_END, 20, "t5b_wait_end");
        push_words(16'h005A, 2, 2, 4);
        stat_q.push_back(8'h40);
        tick(2);
        fo_pulse(5'd0);
        wait_done(100, "t5b_done");
        tick(3);

        // 6a: host back-pressure for 10 cycles
        word_ready = 1'b0;
        start_frame(5'd4);
        wait_state(ST_WAIT_END, 20, "t6a_wait_end");
        push_words(16'h0060, 4, 4, 4);
        stat_q.push_back(8'h00);
        tick(2);
        fo_pulse(5'd0);
        wait_valid(50, "t6a_valid");
        r = rden_cnt;
        tick(10);
        check("t6a_no_extra_rden", rden_cnt - r, 32'd0);
        word_ready = 1'b1;
        wait_done(100, "t6a_done");
        tick(3);

        // 6b: abort with a pending word
        word_ready = 1'b0;
        start_frame(5'd4);
        wait_state(ST_WAIT_END, 20, "t6b_wait_end");
        push_words(16'h00C0, 3, 0, 4);
        stat_q.push_back(8'h00);
        tick(2);
        fo_pulse(5'd0);
        wait_valid(50, "t6b_valid");
        rx_abort = 1'b1;
        tick();
        rx_abort = 1'b0;
        check("t6b_valid_dropped", {31'd0, word_valid}, 32'd0);
        wait_done(100, "t6b_done");
        check("t6b_fifo_flushed", fifo_m.size(), 32'd0);
        word_ready = 1'b1;
        tick(3);

        // 6c: reset mid-DRAIN, then leftover purged by the next frame
        word_ready = 1'b0;
        start_frame(5'd4);
        wait_state(ST_WAIT_END, 20, "t6c_wait_end");
        push_words(16'h00E0, 2, 0, 4);
        tick(2);
        fo_pulse(5'd0);
        wait_valid(50, "t6c_valid");
        rst = 1'b1;
        tick();
        check("t6c_reset_outputs", out_bus()[47:16], 32'd0);
        check("t6c_reset_outputs_lo", {16'd0, out_bus()[15:0]}, 32'd0);
        rst = 1'b0;
        word_ready = 1'b1;
        tick(2);
        r = rden_cnt;
        start_frame(5'd1);
        wait_state(ST_WAIT_END, 30, "t6c_wait_end2");
        check("t6c_leftover_purged", rden_cnt - r, 32'd1);
        push_words(16'h00D1, 1, 1, 1);
        stat_q.push_back(8'h00);
        tick(2);
        fo_pulse(5'd0);
        wait_done(100, "t6c_done");
        tick(3);

        // Boundary: invalid lengths 0 and 17
        stat_q.push_back(8'h01);
        start_frame(5'd0);
        check("len0_idle", {31'd0, rx_busy}, 32'd0);
        wait_done(5, "len0_done");
        stat_q.push_back(8'h01);
        start_frame(5'd17);
        check("len17_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        wait_done(5, "len17_done");
        tick(3);

        // Boundary: maximum length 16
        start_frame(5'd16);
        wait_state(ST_WAIT_END, 20, "len16_wait_end");
        push_words(16'h1000, 16, 16, 16);
        stat_q.push_back(8'h00);
        tick(2);
        fo_pulse(5'd0);
        wait_done(300, "len16_done");
        tick(5);

        check("words_left", exp_q.size(), 32'd0);
        check("status_left", stat_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
